sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester arbiter in front of a single-port SRAM
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration, otherwise requester 0 has fixed priority.
module sram_arbiter #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_add,
  input  logic [DW-1:0] req0_wd,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_add,
  input  logic [DW-1:0] req1_wd,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rd,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rd,
  output logic [AW-1:0] sram_add,
  output logic          sram_we,
  output logic [DW-1:0] sram_wd,
  input  logic [DW-1:0] sram_rd
);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] add_q, add_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] rsp0_rd_q, rsp0_rd_d;
  logic [DW-1:0] rsp1_rd_q, rsp1_rd_d;
  logic          grant0, grant1;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_q);
    grant1 = req1_valid && (!req0_valid || !last_q);
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`endif

  always_comb begin
    state_d    = state_q;
    add_d      = add_q;
    wd_d       = wd_q;
    owner_d    = owner_q;
    rsp0_rd_d  = rsp0_rd_q;
    rsp1_rd_d  = rsp1_rd_q;
`ifdef SRAM_ARB_RR_EN
    last_d     = last_q;
`endif
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = resetn && grant0;
        req1_ready = resetn && grant1;
        if (grant0) begin
          add_d   = req0_add;
          wd_d    = req0_wd;
          owner_d = 1'b0;
          state_d = req0_we ? WR : RD;
`ifdef SRAM_ARB_RR_EN
          last_d  = 1'b0;
`endif
        end else if (grant1) begin
          add_d   = req1_add;
          wd_d    = req1_wd;
          owner_d = 1'b1;
          state_d = req1_we ? WR : RD;
`ifdef SRAM_ARB_RR_EN
          last_d  = 1'b1;
`endif
        end
      end
      WR: begin
        state_d = RSP;
        if (owner_q) rsp1_rd_d = '0;
        else         rsp0_rd_d = '0;
      end
      RD: begin
        // Read data is latched here so it is already valid during the response cycle.
        state_d = RSP;
        if (owner_q) rsp1_rd_d = sram_rd;
        else         rsp0_rd_d = sram_rd;
      end
      RSP: begin
        state_d    = IDLE;
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      add_q     <= '0;
      wd_q      <= '0;
      owner_q   <= 1'b0;
      rsp0_rd_q <= '0;
      rsp1_rd_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      add_q     <= add_d;
      wd_q      <= wd_d;
      owner_q   <= owner_d;
      rsp0_rd_q <= rsp0_rd_d;
      rsp1_rd_q <= rsp1_rd_d;
`ifdef SRAM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign sram_we  = (state_q == WR);
  assign sram_add = add_q;
  assign sram_wd  = wd_q;
  assign rsp0_rd  = rsp0_rd_q;
  assign rsp1_rd  = rsp1_rd_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with an SRAM model and transaction-level reference
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0, req0_ready;
  logic [2:0]  req0_add = '0;
  logic [31:0] req0_wd = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0, req1_ready;
  logic [2:0]  req1_add = '0;
  logic [31:0] req1_wd = '0;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rd, rsp1_rd;
  logic [2:0]  sram_add;
  logic        sram_we;
  logic [31:0] sram_wd, sram_rd;

  logic [31:0] mem [0:7] = '{default: 32'h0};
  logic [31:0] ref_mem [0:7] = '{default: 32'h0};
  logic        exp_last = 1'b1;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(3), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_add(req0_add), .req0_wd(req0_wd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_add(req1_add), .req1_wd(req1_wd), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rd(rsp0_rd), .rsp1_valid(rsp1_valid), .rsp1_rd(rsp1_rd),
    .sram_add(sram_add), .sram_we(sram_we), .sram_wd(sram_wd), .sram_rd(sram_rd)
  );

  assign sram_rd = mem[sram_add];
  always @(posedge clk) if (sram_we) mem[sram_add] <= sram_wd;

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    exp_last = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_add = 3'd4; req0_wd = $urandom;
    req1_valid = 1'b1; req1_we = 1'b0; req1_add = 3'd6; req1_wd = $urandom;
    @(negedge clk);
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b exp=0", req1_ready); end
    total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rst_sram_we got=%b exp=0", sram_we); end
    total++; if (sram_add !== 3'd0) begin bad++; $display("FAIL rst_sram_add got=%h exp=0", sram_add); end
    total++; if (sram_wd !== 32'd0) begin bad++; $display("FAIL rst_sram_wd got=%h exp=0", sram_wd); end
    total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid}); end
    total++; if (rsp0_rd !== 32'd0) begin bad++; $display("FAIL rst_rsp0_rd got=%h exp=0", rsp0_rd); end
    total++; if (rsp1_rd !== 32'd0) begin bad++; $display("FAIL rst_rsp1_rd got=%h exp=0", rsp1_rd); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    exp_last = 1'b1;
    @(negedge clk);
    total++; if ({req0_ready, req1_ready, sram_we} !== 3'b000) begin bad++; $display("FAIL post_rst_idle got=%b exp=000", {req0_ready, req1_ready, sram_we}); end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_add = 3'b001; req0_wd = 32'hAAAAAAAA;
    @(negedge clk);
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL wr_ready got=%b exp=10", {req0_ready, req1_ready}); end
    ref_mem[1] = 32'hAAAAAAAA;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    total++; if ({sram_we, sram_add, sram_wd} !== {1'b1, 3'b001, 32'hAAAAAAAA}) begin bad++; $display("FAIL wr_sram got=%b/%h/%h exp=1/1/aaaaaaaa", sram_we, sram_add, sram_wd); end
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp got=%b exp=0", rsp0_valid); end
    @(negedge clk);
    total++; if ({sram_we, rsp0_valid, rsp1_valid} !== 3'b010) begin bad++; $display("FAIL wr_rsp got=%b exp=010", {sram_we, rsp0_valid, rsp1_valid}); end
    total++; if (rsp0_rd !== 32'd0) begin bad++; $display("FAIL wr_rsp0_rd got=%h exp=0", rsp0_rd); end
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_we = 1'b0; req1_add = 3'b001; req1_wd = $urandom;
    @(negedge clk);
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL rd_ready got=%b exp=01", {req0_ready, req1_ready}); end
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    total++; if ({sram_we, sram_add} !== {1'b0, 3'b001}) begin bad++; $display("FAIL rd_sram got=%b/%h exp=0/1", sram_we, sram_add); end
    @(negedge clk);
    total++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin bad++; $display("FAIL rd_rsp got=%b exp=01", {rsp0_valid, rsp1_valid}); end
    total++; if (rsp1_rd !== ref_mem[1]) begin bad++; $display("FAIL rd_rsp1_rd got=%h exp=%h", rsp1_rd, ref_mem[1]); end
    @(negedge clk);
    total++; if (rsp1_valid !== 1'b0 || rsp1_rd !== ref_mem[1]) begin bad++; $display("FAIL rd_hold got=%b/%h exp=0/%h", rsp1_valid, rsp1_rd, ref_mem[1]); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int rsp_t[$];
    logic [31:0] rsp_d[$];
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_add = 3'd7; req0_wd = 32'hFFFFFFFF;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (rsp0_valid) begin rsp_t.push_back(t); rsp_d.push_back(rsp0_rd); end
      if (req0_valid && req0_ready) begin
        acc.push_back(t);
        @(posedge clk); #1;
        if (acc.size() == 1) begin ref_mem[7] = 32'hFFFFFFFF; req0_we = 1'b0; end
        else req0_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    req0_valid = 1'b0;
    total++;
    if (acc.size() != 2 || rsp_t.size() != 2) begin
      bad++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", acc.size(), rsp_t.size());
    end else begin
      total++; if (acc[1] - acc[0] != 3) begin bad++; $display("FAIL b2b_spacing got=%0d exp=3", acc[1] - acc[0]); end
      total++; if (rsp_t[1] != acc[1] + 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", rsp_t[1], acc[1] + 2); end
      total++; if (rsp_d[0] !== 32'd0) begin bad++; $display("FAIL b2b_wr_rd got=%h exp=0", rsp_d[0]); end
      total++; if (rsp_d[1] !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_rd got=%h exp=ffffffff", rsp_d[1]); end
    end
  endtask

  task automatic test_random();
    int ph;
    logic g0, g1, acc0, acc1, o_own, o_we;
    logic [2:0]  o_add;
    logic [31:0] o_wd, o_rd;
    ph = -1;
    o_own = 1'b0; o_we = 1'b0; o_add = '0; o_wd = '0; o_rd = '0;
    do_reset();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc0 = 1'b0; acc1 = 1'b0;
      if (ph == 0) begin
        total++; if (sram_we !== o_we || sram_add !== o_add) begin bad++; $display("FAIL rnd_access t=%0d got=%b/%h exp=%b/%h", t, sram_we, sram_add, o_we, o_add); end
        if (o_we) begin total++; if (sram_wd !== o_wd) begin bad++; $display("FAIL rnd_wd t=%0d got=%h exp=%h", t, sram_wd, o_wd); end end
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rnd_busy_ready t=%0d got=%b exp=00", t, {req0_ready, req1_ready}); end
      end else if (ph == 1) begin
        total++; if ({rsp0_valid, rsp1_valid} !== {!o_own, o_own} || sram_we !== 1'b0) begin bad++; $display("FAIL rnd_rsp t=%0d got=%b%b we=%b exp=%b%b", t, rsp0_valid, rsp1_valid, sram_we, !o_own, o_own); end
        total++; if ((o_own ? rsp1_rd : rsp0_rd) !== o_rd) begin bad++; $display("FAIL rnd_rsp_rd t=%0d got=%h exp=%h", t, o_own ? rsp1_rd : rsp0_rd, o_rd); end
      end else begin
`ifdef SRAM_ARB_RR_EN
        g0 = req0_valid && (!req1_valid || exp_last == 1'b1);
`else
        g0 = req0_valid;
`endif
        g1 = req1_valid && !g0;
        total++; if ({req0_ready, req1_ready} !== {g0, g1}) begin bad++; $display("FAIL rnd_grant t=%0d got=%b exp=%b", t, {req0_ready, req1_ready}, {g0, g1}); end
        total++; if ({rsp0_valid, rsp1_valid, sram_we} !== 3'b000) begin bad++; $display("FAIL rnd_idle t=%0d got=%b exp=000", t, {rsp0_valid, rsp1_valid, sram_we}); end
        acc0 = req0_valid && req0_ready;
        acc1 = !acc0 && req1_valid && req1_ready;
        if (acc0 || acc1) begin
          o_own = acc1;
          o_we  = acc1 ? req1_we : req0_we;
          o_add = acc1 ? req1_add : req0_add;
          o_wd  = acc1 ? req1_wd : req0_wd;
          o_rd  = o_we ? 32'd0 : ref_mem[o_add];
          if (o_we) ref_mem[o_add] = o_wd;
          exp_last = acc1;
        end
      end
      @(posedge clk); #1;
      if (ph == 1) ph = -1;
      else if (ph == 0) ph = 1;
      else if (acc0 || acc1) ph = 0;
      if (t < 294) begin
        if (acc0 || (req0_valid && $urandom_range(0, 7) == 0)) req0_valid = 1'b0;
        else if (!req0_valid && $urandom_range(0, 2) != 0) begin
          req0_valid = 1'b1; req0_we = 1'($urandom_range(0, 1)); req0_add = 3'($urandom_range(0, 7)); req0_wd = $urandom;
        end
        if (acc1 || (req1_valid && $urandom_range(0, 7) == 0)) req1_valid = 1'b0;
        else if (!req1_valid && $urandom_range(0, 2) != 0) begin
          req1_valid = 1'b1; req1_we = 1'($urandom_range(0, 1)); req1_add = 3'($urandom_range(0, 7)); req1_wd = $urandom;
        end
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
  endtask

  task automatic test_arbitration();
    int gq[$];
    logic a0, a1;
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_add = 3'd2;
    req1_valid = 1'b1; req1_we = 1'b0; req1_add = 3'd5;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      total++; if (a0 && a1) begin bad++; $display("FAIL arb_double t=%0d got=11 exp=one-hot", t); end
      if (rsp0_valid) begin total++; if (rsp0_rd !== ref_mem[2]) begin bad++; $display("FAIL arb_rsp0_rd got=%h exp=%h", rsp0_rd, ref_mem[2]); end end
      if (rsp1_valid) begin total++; if (rsp1_rd !== ref_mem[5]) begin bad++; $display("FAIL arb_rsp1_rd got=%h exp=%h", rsp1_rd, ref_mem[5]); end end
      if (a0) gq.push_back(0);
      else if (a1) gq.push_back(1);
      @(posedge clk); #1;
      if (gq.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    total++;
    if (gq.size() != 4) begin
      bad++; $display("FAIL arb_count got=%0d exp=4", gq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
        total++; if (gq[k] != k % 2) begin bad++; $display("FAIL arb_order k=%0d got=%0d exp=%0d", k, gq[k], k % 2); end
`else
        total++; if (gq[k] != 0) begin bad++; $display("FAIL arb_order k=%0d got=%0d exp=0", k, gq[k]); end
`endif
      end
    end
  endtask

  task automatic test_reset_mid();
    int spurious;
    spurious = 0;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_we = 1'b0; req1_add = 3'd7;
    @(negedge clk);
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL mid_accept got=%b exp=1", req1_ready); end
    @(posedge clk); #1 req1_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    total++; if ({sram_we, sram_add, rsp0_valid, rsp1_valid} !== 6'd0) begin bad++; $display("FAIL mid_rst_outputs got=%b/%h/%b%b exp=0/0/00", sram_we, sram_add, rsp0_valid, rsp1_valid); end
    total++; if (rsp1_rd !== 32'd0) begin bad++; $display("FAIL mid_rst_rsp1_rd got=%h exp=0", rsp1_rd); end
    @(posedge clk); #1 resetn = 1'b1;
    exp_last = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || sram_we) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL mid_dropped got=%0d exp=0", spurious); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_add = 3'd7;
    @(negedge clk);
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL mid_idle_ready got=%b exp=1", req0_ready); end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1 || rsp0_rd !== ref_mem[7]) begin bad++; $display("FAIL mid_next got=%b/%h exp=1/%h", rsp0_valid, rsp0_rd, ref_mem[7]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random();
    test_arbitration();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
